tsc_sync_ctl: RTL and testbench
===============================

// Module: tsc_sync_ctl
// PURPOSE
//  Sequencer for the time stamp counter (tsc) and its phase/frequency detector. Qualifies GPS 1PPS,
//  requests a one-shot TSC resync to GPS, restarts the PFD, then tracks phase error to report lock,
//  holdover and loss. Sits between GPS receiver logic and tsc; drives tsc_sync/pfd_resync.
// PARAMETERS
//  CLK_FREQ      100_000_000  nominal clk cycles per second
//  PPS_TOL       100          allowed |GPS PPS interval - CLK_FREQ| in cycles for a "good" pulse
//  QUAL_CNT      4            consecutive good PPS needed before resync
//  LOCK_THRESH   32           |pdiff| (cycles) at or below which a sample counts as locked
//  UNLOCK_THRESH 1000         |pdiff| above which a sample counts as a phase slip
//  SLIP_CNT      3            consecutive slip samples forcing resync
// PORTS
//  clk          in  1   system clock
//  rst_n        in  1   asynchronous active-low reset
//  gps_3dfix_d  in  1   GPS 3D fix, synchronised level
//  gps_1pps_d   in  1   GPS PPS, single-cycle pulse
//  tsc_1pps_d   in  1   TSC PPS, single-cycle pulse
//  pll_trig     in  1   pulse: pdiff_1pps/fdiff_1pps valid this cycle
//  pdiff_1pps   in  32  signed phase difference TSC-GPS, cycles
//  tsc_sync     out 1   level: tsc reloads on next gps_1pps_d
//  pfd_resync   out 1   single-cycle PFD restart pulse
//  ctl_state    out 3   current state (tsc_ctl_pkg::state_t)
//  locked       out 1   tracking within LOCK_THRESH
//  holdover     out 1   TSC free-running without valid GPS
//  resync_cnt   out 16  resyncs performed (TSC_CTL_STATS_EN)
//  pdiff_max    out 32  max |pdiff| since last resync (TSC_CTL_STATS_EN)
// BEHAVIOUR
//  Reset: all outputs 0, ctl_state=IDLE; interval counter 0. Reset mid-resync drops tsc_sync at once.
//  Interval counter: counts cycles since last gps_1pps_d, clears to 1 on it, saturates at 2^32-1.
//   PPS good iff counter in [CLK_FREQ-PPS_TOL, CLK_FREQ+PPS_TOL] at the pulse; first PPS after
//   IDLE only arms. Missing PPS: counter > CLK_FREQ+PPS_TOL.
//  IDLE : gps_3dfix_d=1 -> QUAL.
//  QUAL : good PPS increments qual count; bad PPS resets it to 0; fix loss -> IDLE.
//         qual count==QUAL_CNT -> SYNC, asserting tsc_sync the same edge.
//  SYNC : tsc_sync held 1. On gps_1pps_d, open 8-cycle window; tsc_1pps_d inside window -> drop
//         tsc_sync, pulse pfd_resync 1 cycle later, resync_cnt+1, clear pdiff_max, -> TRACK.
//         Window expiry without tsc_1pps_d, or 2*CLK_FREQ cycles in SYNC -> QUAL (count 0).
//  TRACK: per pll_trig: |pdiff|<=LOCK_THRESH -> locked=1; >LOCK_THRESH -> locked=0;
//         >UNLOCK_THRESH increments slip count (else clears); slip count==SLIP_CNT -> SYNC.
//         Fix loss or missing PPS -> HOLD.
//  HOLD : holdover=1, locked=0, tsc untouched. Fix present and good PPS -> QUAL (count 1).
//  |pdiff| computed as two's-complement abs; 0x8000_0000 maps to 0x7FFF_FFFF.
//  Priority same cycle: fix loss > PPS timeout > pll_trig evaluation.
//  pll_trig ignored outside TRACK. tsc_sync never asserted outside SYNC.
// CONFIGURATION
//  TSC_CTL_STATS_EN defined: resync_cnt (wraps at 16 bits) and pdiff_max (updated on pll_trig
//  in TRACK) implemented. Undefined: both outputs tied to 0, no registers.
// STRUCTURE
//  tsc_ctl_pkg: state_t enum {IDLE,QUAL,SYNC,TRACK,HOLD}, SYNC_WIN=8, abs32() function.
//  Sub-module pps_qual: interval counter, good/missing flags, one instance.
// TESTING (bench uses CLK_FREQ=1000, PPS_TOL=2, QUAL_CNT=4)
//  fix=1, PPS every 1000 cycles -> QUAL after 1 cycle, SYNC+tsc_sync at 5th PPS (4 good intervals).
//  SYNC, tsc_1pps_d 4 cycles after gps_1pps_d -> tsc_sync 0, pfd_resync 1-cycle pulse, TRACK.
//  TRACK, pdiff=10 on pll_trig -> locked=1; pdiff=-1500 x3 -> locked 0, SYNC, tsc_sync 1.
//  QUAL, one PPS at interval 1005 -> qual count 0, 4 more good PPS needed.
//  TRACK, no PPS for 1003 cycles -> HOLD, holdover=1; good PPS with fix -> QUAL.
//  rst_n low while in SYNC -> tsc_sync 0 asynchronously, IDLE; STATS_EN: resync_cnt 0.

Source files
------------

// File: rtl/tsc_ctl_pkg.sv
// Shared types and helpers for the TSC sync controller.
//   state_t  : controller state encoding (visible on ctl_state)
//   SYNC_WIN : cycles after a GPS PPS in which the TSC PPS must appear during SYNC
//   abs32()  : saturating absolute value of a signed 32-bit phase difference
package tsc_ctl_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        QUAL  = 3'd1,
        SYNC  = 3'd2,
        TRACK = 3'd3,
        HOLD  = 3'd4
    } state_t;

    localparam int unsigned SYNC_WIN = 8;

    // 0x8000_0000 has no positive counterpart, so it saturates to 0x7FFF_FFFF.
    function automatic logic [31:0] abs32(input logic signed [31:0] v);
        if (!v[31]) begin
            return v;
        end
        if (v[30:0] == 31'd0) begin
            return 32'h7FFF_FFFF;
        end
        return 32'(-v);
    endfunction

endpackage

// File: rtl/tsc_sync_ctl_if.sv
// Signal bundle between the GPS/TSC/PFD side and the sync controller.
//   gps_3dfix_d, gps_1pps_d, tsc_1pps_d, pll_trig, pdiff_1pps : towards the controller
//   tsc_sync, pfd_resync, ctl_state, locked, holdover,
//   resync_cnt, pdiff_max                                     : from the controller
// master modport: the driving side (receiver logic / tsc / PFD); slave modport: the controller.
interface tsc_sync_ctl_if;
    import tsc_ctl_pkg::*;

    logic               gps_3dfix_d;
    logic               gps_1pps_d;
    logic               tsc_1pps_d;
    logic               pll_trig;
    logic signed [31:0] pdiff_1pps;
    logic               tsc_sync;
    logic               pfd_resync;
    state_t             ctl_state;
    logic               locked;
    logic               holdover;
    logic [15:0]        resync_cnt;
    logic [31:0]        pdiff_max;

    modport master (
        output gps_3dfix_d, gps_1pps_d, tsc_1pps_d, pll_trig, pdiff_1pps,
        input  tsc_sync, pfd_resync, ctl_state, locked, holdover, resync_cnt, pdiff_max
    );

    modport slave (
        input  gps_3dfix_d, gps_1pps_d, tsc_1pps_d, pll_trig, pdiff_1pps,
        output tsc_sync, pfd_resync, ctl_state, locked, holdover, resync_cnt, pdiff_max
    );

endinterface

// File: rtl/pps_qual.sv
// GPS PPS interval qualifier.
//   clk, rst_n : clock, asynchronous active-low reset
//   pps        : GPS PPS, single-cycle pulse
//   arm_clr    : forget the previous pulse (next pulse only arms)
//   good / bad : pulse arrived with interval inside / outside CLK_FREQ +- PPS_TOL
//   missing    : no pulse for more than CLK_FREQ + PPS_TOL cycles
module pps_qual #(
    parameter int unsigned CLK_FREQ = 100_000_000,
    parameter int unsigned PPS_TOL  = 100
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pps,
    input  logic arm_clr,
    output logic good,
    output logic bad,
    output logic missing
);

    localparam logic [31:0] IVL_LO = 32'(CLK_FREQ - PPS_TOL);
    localparam logic [31:0] IVL_HI = 32'(CLK_FREQ + PPS_TOL);

    logic [31:0] ivl_q, ivl_d;
    logic        armed_q, armed_d;
    logic        in_range;

    // Counter holds the number of cycles since the last pulse, as seen on the next pulse.
    always_comb begin
        ivl_d = ivl_q;
        if (pps) begin
            ivl_d = 32'd1;
        end else if (ivl_q != 32'hFFFF_FFFF) begin
            ivl_d = ivl_q + 32'd1;
        end
        armed_d = arm_clr ? 1'b0 : (armed_q | pps);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ivl_q   <= '0;
            armed_q <= 1'b0;
        end else begin
            ivl_q   <= ivl_d;
            armed_q <= armed_d;
        end
    end

    assign in_range = (ivl_q >= IVL_LO) && (ivl_q <= IVL_HI);
    assign good     = pps & armed_q & in_range;
    assign bad      = pps & armed_q & ~in_range;
    assign missing  = ivl_q > IVL_HI;

endmodule

// File: rtl/tsc_sync_ctl.sv
// TSC / PFD sequencer: qualifies GPS PPS, requests a one-shot TSC resync, restarts the PFD,
// then tracks phase error to report lock, holdover and loss.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : tsc_sync_ctl_if.slave (GPS/TSC/PFD inputs, control and status outputs)
// Optional: define TSC_CTL_STATS_EN to implement resync_cnt and pdiff_max; otherwise both
// read as 0 and no registers are built.
module tsc_sync_ctl
    import tsc_ctl_pkg::*;
#(
    parameter int unsigned CLK_FREQ      = 100_000_000,
    parameter int unsigned PPS_TOL       = 100,
    parameter int unsigned QUAL_CNT      = 4,
    parameter int unsigned LOCK_THRESH   = 32,
    parameter int unsigned UNLOCK_THRESH = 1000,
    parameter int unsigned SLIP_CNT      = 3
) (
    input logic           clk,
    input logic           rst_n,
    tsc_sync_ctl_if.slave bus
);

    localparam logic [7:0]  QUAL_LAST = 8'(QUAL_CNT - 1);
    localparam logic [7:0]  SLIP_LAST = 8'(SLIP_CNT - 1);
    localparam logic [31:0] SYNC_TMO  = 32'(2 * CLK_FREQ - 1);
    localparam logic [3:0]  WIN_LEN   = 4'(SYNC_WIN);

    state_t      state_q, state_d;
    logic [7:0]  qual_cnt_q, qual_cnt_d;
    logic [7:0]  slip_cnt_q, slip_cnt_d;
    logic [3:0]  win_q, win_d;
    logic [31:0] sync_tmr_q, sync_tmr_d;
    logic        tsc_sync_q, tsc_sync_d;
    logic        pfd_pend_q, pfd_pend_d;
    logic        pfd_resync_q;
    logic        locked_q, locked_d;
    logic        pps_good, pps_bad, pps_missing;
    logic [31:0] pdiff_abs;

    pps_qual #(
        .CLK_FREQ (CLK_FREQ),
        .PPS_TOL  (PPS_TOL)
    ) u_pps_qual (
        .clk     (clk),
        .rst_n   (rst_n),
        .pps     (bus.gps_1pps_d),
        .arm_clr (state_q == IDLE),
        .good    (pps_good),
        .bad     (pps_bad),
        .missing (pps_missing)
    );

    assign pdiff_abs = abs32(bus.pdiff_1pps);

    always_comb begin
        state_d    = state_q;
        qual_cnt_d = qual_cnt_q;
        slip_cnt_d = slip_cnt_q;
        win_d      = win_q;
        sync_tmr_d = '0;
        tsc_sync_d = tsc_sync_q;
        pfd_pend_d = 1'b0;
        locked_d   = locked_q;
        unique case (state_q)
            IDLE: begin
                qual_cnt_d = '0;
                tsc_sync_d = 1'b0;
                locked_d   = 1'b0;
                if (bus.gps_3dfix_d) state_d = QUAL;
            end
            QUAL: begin
                if (!bus.gps_3dfix_d) begin
                    state_d    = IDLE;
                    qual_cnt_d = '0;
                end else if (pps_good) begin
                    if (qual_cnt_q >= QUAL_LAST) begin
                        state_d    = SYNC;
                        qual_cnt_d = '0;
                        tsc_sync_d = 1'b1;
                        win_d      = '0;
                    end else begin
                        qual_cnt_d = qual_cnt_q + 8'd1;
                    end
                end else if (pps_bad) begin
                    qual_cnt_d = '0;
                end
            end
            SYNC: begin
                sync_tmr_d = sync_tmr_q + 32'd1;
                // win_q counts down the cycles left after the GPS PPS that opened the window.
                if ((win_q != 4'd0) && bus.tsc_1pps_d) begin
                    state_d    = TRACK;
                    tsc_sync_d = 1'b0;
                    pfd_pend_d = 1'b1;
                    win_d      = '0;
                    slip_cnt_d = '0;
                    locked_d   = 1'b0;
                end else if ((win_q == 4'd1) || (sync_tmr_q == SYNC_TMO)) begin
                    state_d    = QUAL;
                    qual_cnt_d = '0;
                    tsc_sync_d = 1'b0;
                    win_d      = '0;
                end else if (win_q != 4'd0) begin
                    win_d = win_q - 4'd1;
                end else if (bus.gps_1pps_d) begin
                    win_d = WIN_LEN;
                end
            end
            TRACK: begin
                if (!bus.gps_3dfix_d || pps_missing) begin
                    state_d    = HOLD;
                    locked_d   = 1'b0;
                    slip_cnt_d = '0;
                end else if (bus.pll_trig) begin
                    locked_d = pdiff_abs <= LOCK_THRESH;
                    if (pdiff_abs > UNLOCK_THRESH) begin
                        if (slip_cnt_q >= SLIP_LAST) begin
                            state_d    = SYNC;
                            slip_cnt_d = '0;
                            tsc_sync_d = 1'b1;
                            win_d      = '0;
                            locked_d   = 1'b0;
                        end else begin
                            slip_cnt_d = slip_cnt_q + 8'd1;
                        end
                    end else begin
                        slip_cnt_d = '0;
                    end
                end
            end
            HOLD: begin
                locked_d = 1'b0;
                if (bus.gps_3dfix_d && pps_good) begin
                    state_d    = QUAL;
                    qual_cnt_d = 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            qual_cnt_q   <= '0;
            slip_cnt_q   <= '0;
            win_q        <= '0;
            sync_tmr_q   <= '0;
            tsc_sync_q   <= 1'b0;
            pfd_pend_q   <= 1'b0;
            pfd_resync_q <= 1'b0;
            locked_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            qual_cnt_q   <= qual_cnt_d;
            slip_cnt_q   <= slip_cnt_d;
            win_q        <= win_d;
            sync_tmr_q   <= sync_tmr_d;
            tsc_sync_q   <= tsc_sync_d;
            pfd_pend_q   <= pfd_pend_d;
            pfd_resync_q <= pfd_pend_q;
            locked_q     <= locked_d;
        end
    end

    assign bus.tsc_sync   = tsc_sync_q;
    assign bus.pfd_resync = pfd_resync_q;
    assign bus.ctl_state  = state_q;
    assign bus.locked     = locked_q;
    assign bus.holdover   = (state_q == HOLD);

`ifdef TSC_CTL_STATS_EN
    logic [15:0] resync_cnt_q;
    logic [31:0] pdiff_max_q;
    logic        pdiff_upd;

    // Same condition under which TRACK evaluates pll_trig.
    assign pdiff_upd = (state_q == TRACK) && bus.gps_3dfix_d && !pps_missing && bus.pll_trig;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resync_cnt_q <= '0;
            pdiff_max_q  <= '0;
        end else if (pfd_pend_d) begin
            resync_cnt_q <= resync_cnt_q + 16'd1;
            pdiff_max_q  <= '0;
        end else if (pdiff_upd && (pdiff_abs > pdiff_max_q)) begin
            pdiff_max_q <= pdiff_abs;
        end
    end

    assign bus.resync_cnt = resync_cnt_q;
    assign bus.pdiff_max  = pdiff_max_q;
`else
    assign bus.resync_cnt = '0;
    assign bus.pdiff_max  = '0;
`endif

endmodule

// File: tb/tb_tsc_sync_ctl.sv
// Directed bench for tsc_sync_ctl with CLK_FREQ=1000, PPS_TOL=2, QUAL_CNT=4.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_tsc_sync_ctl;

    localparam int unsigned CLK_FREQ = 1000;
    localparam int unsigned PPS_TOL  = 2;
    localparam int unsigned QUAL_CNT = 4;

    localparam logic [31:0] ST_IDLE  = 32'd0;
    localparam logic [31:0] ST_QUAL  = 32'd1;
    localparam logic [31:0] ST_SYNC  = 32'd2;
    localparam logic [31:0] ST_TRACK = 32'd3;
    localparam logic [31:0] ST_HOLD  = 32'd4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    tsc_sync_ctl_if bus ();

    tsc_sync_ctl #(
        .CLK_FREQ      (CLK_FREQ),
        .PPS_TOL       (PPS_TOL),
        .QUAL_CNT      (QUAL_CNT),
        .LOCK_THRESH   (32),
        .UNLOCK_THRESH (1000),
        .SLIP_CNT      (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Expected statistics value: real value when the stats build is selected, else 0.
    function automatic logic [31:0] sx(input logic [31:0] v);
`ifdef TSC_CTL_STATS_EN
        return v;
`else
        return (v & 32'd0);
`endif
    endfunction

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic gps_pulse();
        bus.gps_1pps_d = 1'b1;
        @(negedge clk);
        bus.gps_1pps_d = 1'b0;
    endtask

    // Next GPS pulse lands n edges after the previous one (call right after gps_pulse).
    task automatic pps_every(input int n);
        step(n - 1);
        gps_pulse();
    endtask

    task automatic tsc_pulse();
        bus.tsc_1pps_d = 1'b1;
        @(negedge clk);
        bus.tsc_1pps_d = 1'b0;
    endtask

    task automatic trig(input logic [31:0] p);
        bus.pdiff_1pps = p;
        bus.pll_trig   = 1'b1;
        @(negedge clk);
        bus.pll_trig   = 1'b0;
    endtask

    task automatic chk_state(input string tag, input logic [31:0] exp);
        check(tag, 32'(bus.ctl_state), exp);
    endtask

    initial begin
        bus.gps_3dfix_d = 1'b0;
        bus.gps_1pps_d  = 1'b0;
        bus.tsc_1pps_d  = 1'b0;
        bus.pll_trig    = 1'b0;
        bus.pdiff_1pps  = '0;
        step(2);
        chk_state("rst_state", ST_IDLE);
        check("rst_tsc_sync", 32'(bus.tsc_sync), 0);
        check("rst_pfd", 32'(bus.pfd_resync), 0);
        check("rst_locked", 32'(bus.locked), 0);
        check("rst_holdover", 32'(bus.holdover), 0);
        check("rst_resync_cnt", 32'(bus.resync_cnt), 0);
        check("rst_pdiff_max", bus.pdiff_max, 0);
        rst_n = 1'b1;
        step(3);
        chk_state("idle_nofix", ST_IDLE);

        // Fix acquire / loss / reacquire
        bus.gps_3dfix_d = 1'b1;
        step(1);
        chk_state("fix_to_qual", ST_QUAL);
        bus.gps_3dfix_d = 1'b0;
        step(1);
        chk_state("fixloss_to_idle", ST_IDLE);
        bus.gps_3dfix_d = 1'b1;
        step(1);
        chk_state("refix_to_qual", ST_QUAL);

        // First PPS arms, four good intervals reach SYNC
        gps_pulse();
        for (int i = 2; i <= 5; i++) begin
            pps_every(1000);
            if (i < 5) begin
                chk_state($sformatf("qual_pps%0d", i), ST_QUAL);
                check($sformatf("qual_tsc_sync%0d", i), 32'(bus.tsc_sync), 0);
            end
        end
        chk_state("qual_to_sync", ST_SYNC);
        check("sync_tsc_sync", 32'(bus.tsc_sync), 1);

        // TSC PPS 4 cycles after GPS PPS completes the resync
        pps_every(1000);
        step(3);
        tsc_pulse();
        chk_state("sync_to_track", ST_TRACK);
        check("track_tsc_sync", 32'(bus.tsc_sync), 0);
        check("pfd_before", 32'(bus.pfd_resync), 0);
        step(1);
        check("pfd_pulse", 32'(bus.pfd_resync), 1);
        step(1);
        check("pfd_after", 32'(bus.pfd_resync), 0);
        check("resync_cnt1", 32'(bus.resync_cnt), sx(1));

        // Lock thresholds and slip counting
        trig(32'd10);
        check("lock_10", 32'(bus.locked), 1);
        check("pmax_10", bus.pdiff_max, sx(10));
        trig(32'd33);
        check("lock_33", 32'(bus.locked), 0);
        trig(32'd32);
        check("lock_32", 32'(bus.locked), 1);
        check("pmax_33", bus.pdiff_max, sx(33));
        trig(32'hFFFF_FA24);
        check("lock_m1500", 32'(bus.locked), 0);
        chk_state("slip1", ST_TRACK);
        trig(32'hFFFF_FA24);
        chk_state("slip2", ST_TRACK);
        trig(32'd1000);
        chk_state("slip_clear", ST_TRACK);
        check("pmax_1500", bus.pdiff_max, sx(1500));
        trig(32'hFFFF_FA24);
        trig(32'hFFFF_FA24);
        chk_state("reslip2", ST_TRACK);
        trig(32'hFFFF_FA24);
        chk_state("slip_to_sync", ST_SYNC);
        check("slip_tsc_sync", 32'(bus.tsc_sync), 1);
        check("slip_locked", 32'(bus.locked), 0);

        // Window expiry with no TSC PPS
        gps_pulse();
        step(7);
        chk_state("win_last", ST_SYNC);
        step(1);
        chk_state("win_expire", ST_QUAL);
        check("win_tsc_sync", 32'(bus.tsc_sync), 0);

        // Bad interval clears the qualification count
        step(991);
        gps_pulse();
        pps_every(1000);
        pps_every(1005);
        chk_state("bad_pps", ST_QUAL);
        pps_every(998);
        chk_state("good_998", ST_QUAL);
        pps_every(1002);
        chk_state("good_1002", ST_QUAL);
        pps_every(1000);
        chk_state("good3_after_bad", ST_QUAL);
        pps_every(1000);
        chk_state("good4_after_bad", ST_SYNC);

        // Second resync, then PPS loss to holdover
        pps_every(1000);
        step(3);
        tsc_pulse();
        chk_state("sync_to_track2", ST_TRACK);
        check("resync_cnt2", 32'(bus.resync_cnt), sx(2));
        check("pmax_cleared", bus.pdiff_max, sx(0));
        trig(32'd5);
        check("lock_5", 32'(bus.locked), 1);
        step(997);
        chk_state("pps_1002", ST_TRACK);
        check("holdover_0", 32'(bus.holdover), 0);
        step(1);
        chk_state("pps_missing", ST_HOLD);
        check("holdover_1", 32'(bus.holdover), 1);
        check("hold_unlocked", 32'(bus.locked), 0);

        // Recovery: stale pulse is bad, next good pulse re-enters QUAL with count 1
        step(5);
        gps_pulse();
        chk_state("hold_bad_pps", ST_HOLD);
        pps_every(1000);
        chk_state("hold_to_qual", ST_QUAL);
        check("holdover_clr", 32'(bus.holdover), 0);
        pps_every(1000);
        pps_every(1000);
        chk_state("hold_qual3", ST_QUAL);
        pps_every(1000);
        chk_state("hold_qual4_sync", ST_SYNC);
        check("hold_sync_tsc", 32'(bus.tsc_sync), 1);

        // Asynchronous reset while in SYNC
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_tsc_sync", 32'(bus.tsc_sync), 0);
        chk_state("arst_state", ST_IDLE);
        check("arst_resync_cnt", 32'(bus.resync_cnt), 0);
        step(1);
        rst_n = 1'b1;
        step(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
